// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the fetch/data requesters, the arbiter and the memory.
// master: arbiter view; slave: requester/memory view.
interface mem_port_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic            i_req;
    logic [AW-1:0]   i_addr;
    logic            i_gnt;
    logic            i_rvalid;
    logic [DW-1:0]   i_rdata;

    logic            d_req;
    logic            d_we;
    logic [DW/8-1:0] d_be;
    logic [AW-1:0]   d_addr;
    logic [DW-1:0]   d_wdata;
    logic            d_gnt;
    logic            d_rvalid;
    logic [DW-1:0]   d_rdata;

    logic            mem_req;
    logic            mem_we;
    logic [DW/8-1:0] mem_be;
    logic [AW-1:0]   mem_addr;
    logic [DW-1:0]   mem_wdata;
    logic            mem_gnt;
    logic            mem_rvalid;
    logic [DW-1:0]   mem_rdata;

    modport master (
        input  i_req, i_addr,
        output i_gnt, i_rvalid, i_rdata,
        input  d_req, d_we, d_be, d_addr, d_wdata,
        output d_gnt, d_rvalid, d_rdata,
        output mem_req, mem_we, mem_be, mem_addr, mem_wdata,
        input  mem_gnt, mem_rvalid, mem_rdata
    );

    modport slave (
        output i_req, i_addr,
        input  i_gnt, i_rvalid, i_rdata,
        output d_req, d_we, d_be, d_addr, d_wdata,
        input  d_gnt, d_rvalid, d_rdata,
        input  mem_req, mem_we, mem_be, mem_addr, mem_wdata,
        output mem_gnt, mem_rvalid, mem_rdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between fetch (I) and data (D) ports.
// Ports: clk, reset_n, bus (master modport), busy, protocol_err.
module mem_port_arbiter #(
    parameter int AW         = 32,
    parameter int DW         = 32,
    parameter int MAX_STREAK = 4
) (
    input  logic               clk,
    input  logic               reset_n,
    mem_port_arbiter_if.master bus,
    output logic               busy,
    output logic               protocol_err
);
    localparam int SW = $clog2(MAX_STREAK + 1);
    localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_STREAK);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_I,
        WAIT_D
    } state_t;

    state_t        state;
    logic          lock;
    logic          lock_d;
    logic [SW-1:0] streak;

    logic idle;
    logic win_d;
    logic req;
    logic grant;

    // While a stalled request is locked, the earlier winner is kept so the
    // address seen by memory never changes before it is accepted.
    always_comb begin
        idle  = (state == IDLE);
        win_d = lock ? lock_d
                     : (bus.d_req & ~(bus.i_req & (streak == STREAK_MAX)));
        req   = reset_n & idle & (lock | bus.i_req | bus.d_req);
        grant = req & bus.mem_gnt;
    end

    assign bus.mem_req   = req;
    assign bus.mem_we    = req & win_d & bus.d_we;
    assign bus.mem_be    = !req ? '0 : (win_d ? bus.d_be : '1);
    assign bus.mem_addr  = !req ? '0 : (win_d ? bus.d_addr : bus.i_addr);
    assign bus.mem_wdata = (req & win_d) ? bus.d_wdata : '0;

    assign bus.i_gnt    = grant & ~win_d;
    assign bus.d_gnt    = grant & win_d;
    assign bus.i_rvalid = (state == WAIT_I) & bus.mem_rvalid;
    assign bus.d_rvalid = (state == WAIT_D) & bus.mem_rvalid;
    assign bus.i_rdata  = bus.i_rvalid ? bus.mem_rdata : '0;
    assign bus.d_rdata  = bus.d_rvalid ? bus.mem_rdata : '0;

    assign busy = ~idle | req;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            lock         <= 1'b0;
            lock_d       <= 1'b0;
            streak       <= '0;
            protocol_err <= 1'b0;
        end else begin
            // A response with nothing outstanding is dropped and flagged.
            if (idle && bus.mem_rvalid) begin
                protocol_err <= 1'b1;
            end
            unique case (state)
                IDLE: begin
                    if (grant) begin
                        state <= win_d ? WAIT_D : WAIT_I;
                        lock  <= 1'b0;
                        if (win_d && bus.i_req) begin
                            if (streak != STREAK_MAX) begin
                                streak <= streak + SW'(1);
                            end
                        end else begin
                            streak <= '0;
                        end
                    end else if (req) begin
                        lock   <= 1'b1;
                        lock_d <= win_d;
                    end
                end
                WAIT_I, WAIT_D: begin
                    if (bus.mem_rvalid) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios followed by
// randomized traffic compared against a transaction-level reference model.
module tb_mem_port_arbiter;
    localparam int MAXS = 4;

    logic clk = 1'b0;
    logic reset_n;
    logic busy;
    logic protocol_err;

    int n_chk  = 0;
    int n_fail = 0;

    mem_port_arbiter_if #(.AW(32), .DW(32)) bus ();

    mem_port_arbiter #(.AW(32), .DW(32), .MAX_STREAK(MAXS)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .bus          (bus),
        .busy         (busy),
        .protocol_err (protocol_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference model state: owner/held are 0 none, 1 fetch, 2 data.
    int owner;
    int held;
    int dstreak;
    int win;
    bit drop_i;
    bit drop_d;
    logic [31:0] e_addr;
    logic [31:0] e_wdata;
    logic [3:0]  e_be;
    logic        e_we;

    initial begin
        reset_n        = 1'b0;
        bus.i_req      = 1'b0;
        bus.i_addr     = '0;
        bus.d_req      = 1'b0;
        bus.d_we       = 1'b0;
        bus.d_be       = '0;
        bus.d_addr     = '0;
        bus.d_wdata    = '0;
        bus.mem_gnt    = 1'b0;
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata  = '0;
        #2;
        chk("rst_busy", busy, 0);
        chk("rst_mem_req", bus.mem_req, 0);
        chk("rst_mem_addr", bus.mem_addr, 0);
        chk("rst_perr", protocol_err, 0);
        step();
        reset_n = 1'b1;

        // Single fetch
        step();
        bus.i_req = 1'b1; bus.i_addr = 32'h100; bus.mem_gnt = 1'b1;
        #1;
        chk("f_mem_req", bus.mem_req, 1);
        chk("f_mem_addr", bus.mem_addr, 32'h100);
        chk("f_mem_we", bus.mem_we, 0);
        chk("f_mem_be", bus.mem_be, 4'hf);
        chk("f_mem_wdata", bus.mem_wdata, 0);
        chk("f_i_gnt", bus.i_gnt, 1);
        chk("f_d_gnt", bus.d_gnt, 0);
        step();
        bus.i_req = 1'b0; bus.mem_gnt = 1'b0;
        #1;
        chk("f_wait_busy", busy, 1);
        chk("f_wait_req", bus.mem_req, 0);
        step();
        bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'hDEADBEEF;
        #1;
        chk("f_i_rvalid", bus.i_rvalid, 1);
        chk("f_i_rdata", bus.i_rdata, 32'hDEADBEEF);
        chk("f_d_rvalid", bus.d_rvalid, 0);
        chk("f_d_rdata", bus.d_rdata, 0);
        step();
        bus.mem_rvalid = 1'b0;
        #1;
        chk("f_idle_busy", busy, 0);

        // Data write
        bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_be = 4'b0011;
        bus.d_addr = 32'h2000; bus.d_wdata = 32'h1234; bus.mem_gnt = 1'b1;
        #1;
        chk("w_mem_we", bus.mem_we, 1);
        chk("w_mem_be", bus.mem_be, 4'b0011);
        chk("w_mem_addr", bus.mem_addr, 32'h2000);
        chk("w_mem_wdata", bus.mem_wdata, 32'h1234);
        chk("w_d_gnt", bus.d_gnt, 1);
        step();
        bus.d_req = 1'b0; bus.d_we = 1'b0; bus.mem_gnt = 1'b0;
        step();
        bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h55;
        #1;
        chk("w_d_rvalid", bus.d_rvalid, 1);
        chk("w_i_rvalid", bus.i_rvalid, 0);
        step();
        bus.mem_rvalid = 1'b0;

        // Contention: four D grants, then I, then D again
        bus.i_req = 1'b1; bus.i_addr = 32'h104;
        bus.d_req = 1'b1; bus.d_addr = 32'h2004;
        for (int k = 0; k < 6; k++) begin
            bus.mem_gnt = 1'b1;
            #1;
            chk("c_d_gnt", bus.d_gnt, (k == 4) ? 0 : 1);
            chk("c_i_gnt", bus.i_gnt, (k == 4) ? 1 : 0);
            step();
            bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b1;
            step();
            bus.mem_rvalid = 1'b0;
        end
        bus.i_req = 1'b0; bus.d_req = 1'b0;

        // Grant stall with fetch arriving mid-stall
        step();
        bus.d_req = 1'b1; bus.d_addr = 32'h3000;
        for (int k = 0; k < 4; k++) begin
            if (k == 1) begin
                bus.i_req = 1'b1; bus.i_addr = 32'h400;
            end
            bus.mem_gnt = (k == 3);
            #1;
            chk("s_mem_addr", bus.mem_addr, 32'h3000);
            chk("s_d_gnt", bus.d_gnt, (k == 3) ? 1 : 0);
            chk("s_i_gnt", bus.i_gnt, 0);
            step();
        end
        bus.d_req = 1'b0; bus.i_req = 1'b0; bus.mem_gnt = 1'b0;
        step();
        bus.mem_rvalid = 1'b1;
        step();
        bus.mem_rvalid = 1'b0;

        // Stray response in IDLE
        step();
        bus.mem_rvalid = 1'b1;
        #1;
        chk("x_i_rvalid", bus.i_rvalid, 0);
        chk("x_d_rvalid", bus.d_rvalid, 0);
        step();
        bus.mem_rvalid = 1'b0;
        #1;
        chk("x_perr", protocol_err, 1);
        step();
        chk("x_perr_sticky", protocol_err, 1);

        // Reset while waiting on a fetch response
        bus.i_req = 1'b1; bus.i_addr = 32'h500; bus.mem_gnt = 1'b1;
        step();
        bus.i_req = 1'b0; bus.mem_gnt = 1'b0;
        #1;
        chk("r_busy_before", busy, 1);
        reset_n = 1'b0;
        #1;
        chk("r_busy_reset", busy, 0);
        chk("r_perr_reset", protocol_err, 0);
        step();
        reset_n = 1'b1;
        step();
        bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'hCAFE;
        #1;
        chk("r_late_i_rvalid", bus.i_rvalid, 0);
        step();
        bus.mem_rvalid = 1'b0;
        #1;
        chk("r_late_perr", protocol_err, 1);
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;

        // Randomized traffic against the reference model
        owner = 0; held = 0; dstreak = 0;
        drop_i = 0; drop_d = 0;
        for (int cyc = 0; cyc < 2000; cyc++) begin
            step();
            if (drop_i) bus.i_req = 1'b0;
            if (drop_d) bus.d_req = 1'b0;
            drop_i = 0; drop_d = 0;
            if (!bus.i_req && $urandom_range(0, 2) == 0) begin
                bus.i_req  = 1'b1;
                bus.i_addr = $urandom;
            end
            if (!bus.d_req && $urandom_range(0, 1) == 0) begin
                bus.d_req   = 1'b1;
                bus.d_we    = 1'($urandom_range(0, 1));
                bus.d_be    = 4'($urandom);
                bus.d_addr  = $urandom;
                bus.d_wdata = $urandom;
            end
            bus.mem_rvalid = (owner != 0) && ($urandom_range(0, 1) == 1);
            bus.mem_gnt    = !bus.mem_rvalid && ($urandom_range(0, 2) != 0);
            bus.mem_rdata  = $urandom;
            #1;

            win = 0;
            if (owner == 0) begin
                if (held != 0) win = held;
                else if (bus.d_req && !(bus.i_req && dstreak >= MAXS)) win = 2;
                else if (bus.i_req) win = 1;
            end
            e_addr  = (win == 2) ? bus.d_addr : (win == 1) ? bus.i_addr : 32'h0;
            e_wdata = (win == 2) ? bus.d_wdata : 32'h0;
            e_be    = (win == 2) ? bus.d_be : (win == 1) ? 4'hf : 4'h0;
            e_we    = (win == 2) && bus.d_we;

            chk("m_mem_req", bus.mem_req, win != 0);
            chk("m_mem_addr", bus.mem_addr, e_addr);
            chk("m_mem_we", bus.mem_we, e_we);
            chk("m_mem_be", bus.mem_be, e_be);
            chk("m_mem_wdata", bus.mem_wdata, e_wdata);
            chk("m_i_gnt", bus.i_gnt, (win == 1) && bus.mem_gnt);
            chk("m_d_gnt", bus.d_gnt, (win == 2) && bus.mem_gnt);
            chk("m_i_rvalid", bus.i_rvalid, (owner == 1) && bus.mem_rvalid);
            chk("m_d_rvalid", bus.d_rvalid, (owner == 2) && bus.mem_rvalid);
            chk("m_i_rdata", bus.i_rdata,
                ((owner == 1) && bus.mem_rvalid) ? bus.mem_rdata : 32'h0);
            chk("m_d_rdata", bus.d_rdata,
                ((owner == 2) && bus.mem_rvalid) ? bus.mem_rdata : 32'h0);
            chk("m_busy", busy, (owner != 0) || (win != 0));
            chk("m_perr", protocol_err, 0);

            if (owner != 0) begin
                if (bus.mem_rvalid) owner = 0;
            end else if (win != 0 && bus.mem_gnt) begin
                if (win == 2 && bus.i_req)
                    dstreak = (dstreak < MAXS) ? dstreak + 1 : MAXS;
                else
                    dstreak = 0;
                owner = win;
                held  = 0;
                if (win == 1) drop_i = 1;
                else drop_d = 1;
            end else if (win != 0) begin
                held = win;
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
